aes_key_expand: RTL and testbench

Parametrised AES key-schedule engine supporting AES-128/192/256, selected per operation by a runtime mode input. Generates one 32-bit schedule word per cycle using the FIPS-197 recurrence. Stores all round keys in an internal memory with a combinational read port for the cipher datapath. The S-box is external and combinational, shared with the cipher core over a 32-bit sub_in/sub_out pair.

---
 rtl/aes_key_expand.sv | 198 +++++++++++++++++++
 tb/tb_aes_key_expand.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// AES-128/192/256 key-schedule engine: one schedule word per cycle, round keys held in an
// internal memory with a combinational read port. Define AES_KEY_ZEROIZE_EN to add a zeroize input.
module aes_key_expand #(
    parameter int MAX_KEY_BITS      = 256,
    parameter bit MEM_CLEAR_ON_INIT = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic                    zeroize,
`endif
    input  logic                    init,
    input  logic [1:0]              mode,
    input  logic [MAX_KEY_BITS-1:0] key,
    input  logic [3:0]              round,
    output logic [127:0]            round_key,
    output logic                    ready,
    output logic                    busy,
    output logic                    mode_err,
    output logic [31:0]             sub_in,
    input  logic [31:0]             sub_out
);
    localparam int MAX_NK = MAX_KEY_BITS / 32;
    localparam int MAX_NR = MAX_NK + 6;
    localparam int DEPTH  = MAX_NR + 1;

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [5:0]               i_q, i_d;
    logic [2:0]               j_q, j_d;
    logic [7:0]               rcon_q, rcon_d;
    logic [1:0]               mode_q, mode_d;
    logic [7:0][31:0]         key_q, key_d, win_q, win_d, key_words;
    logic [DEPTH-1:0][3:0][31:0] mem_q, mem_d;
    logic                     wr_en_q, wr_en_d;
    logic [5:0]               wr_idx_q, wr_idx_d;
    logic [31:0]              wr_word_q, wr_word_d;
    logic                     ready_q, ready_d, busy_q, busy_d, err_q, err_d;

    logic [3:0]  nk_in, nk, nr;
    logic [5:0]  nw;
    logic [2:0]  nk_m1;
    logic        mode_ok;
    logic [31:0] rot, w_new;

    function automatic logic [3:0] nk_of(input logic [1:0] m);
        case (m)
            2'd0:    return 4'd4;
            2'd1:    return 4'd6;
            2'd2:    return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Key word 0 is the MSB word; words beyond the configured key width read zero.
    for (genvar g = 0; g < 8; g++) begin : g_kw
        if (g < MAX_NK) begin : g_used
            assign key_words[g] = key[MAX_KEY_BITS-1-32*g -: 32];
        end else begin : g_pad
            assign key_words[g] = 32'h0;
        end
    end

    always_comb begin
        nk_in   = nk_of(mode);
        mode_ok = (mode != 2'd3) && ({nk_in, 5'b0} <= 9'(MAX_KEY_BITS));
        nk      = nk_of(mode_q);
        nr      = nk + 4'd6;
        nw      = {nk + 4'd7, 2'b00};
        nk_m1   = 3'(nk - 4'd1);
        rot     = {sub_out[23:0], sub_out[31:24]};

        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        rcon_d    = rcon_q;
        mode_d    = mode_q;
        key_d     = key_q;
        win_d     = win_q;
        mem_d     = mem_q;
        wr_en_d   = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_word_d = wr_word_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        err_d     = err_q;
        sub_in    = 32'h0;
        w_new     = 32'h0;

        // Memory write is registered one cycle behind generation to keep the S-box path short.
        if (wr_en_q) mem_d[wr_idx_q[5:2]][~wr_idx_q[1:0]] = wr_word_q;

        case (state_q)
            IDLE: if (init) begin
                ready_d = 1'b0;
                if (!mode_ok) begin
                    err_d = 1'b1;
                end else begin
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    mode_d  = mode;
                    key_d   = key_words;
                    i_d     = 6'd0;
                    j_d     = 3'd0;
                    rcon_d  = 8'h01;
                    state_d = GEN;
                    if (MEM_CLEAR_ON_INIT) mem_d = '0;
                end
            end
            GEN: begin
                if ({2'b00, nk} > i_q) begin
                    w_new = key_q[i_q[2:0]];
                end else begin
                    sub_in = win_q[0];
                    if (j_q == 3'd0) begin
                        w_new  = win_q[nk_m1] ^ rot ^ {rcon_q, 24'h0};
                        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    end else if (nk == 4'd8 && j_q == 3'd4) begin
                        w_new = win_q[nk_m1] ^ sub_out;
                    end else begin
                        w_new = win_q[nk_m1] ^ win_q[0];
                    end
                end
                win_d     = {win_q[6:0], w_new};
                wr_en_d   = 1'b1;
                wr_idx_d  = i_q;
                wr_word_d = w_new;
                i_d       = i_q + 6'd1;
                j_d       = (j_q == nk_m1) ? 3'd0 : j_q + 3'd1;
                if (i_q == nw - 6'd1) state_d = DONE;
            end
            DONE: if (!wr_en_q) begin
                // One extra cycle lets the final registered write land before ready.
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef AES_KEY_ZEROIZE_EN
        if (zeroize) begin
            mem_d   = '0;
            win_d   = '0;
            key_d   = '0;
            wr_en_d = 1'b0;
            ready_d = 1'b0;
            busy_d  = 1'b0;
            i_d     = 6'd0;
            j_d     = 3'd0;
            rcon_d  = 8'h01;
            state_d = IDLE;
        end
`endif

        round_key = '0;
        if (round <= nr) round_key = mem_q[round];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            rcon_q    <= 8'h01;
            mode_q    <= '0;
            key_q     <= '0;
            win_q     <= '0;
            mem_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_word_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            rcon_q    <= rcon_d;
            mode_q    <= mode_d;
            key_q     <= key_d;
            win_q     <= win_d;
            mem_q     <= mem_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_word_q <= wr_word_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign mode_err = err_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: FIPS-197 vectors, latency, mode error, abort and rerun.
module tb_aes_key_expand;
    logic         clk = 1'b0, reset = 1'b0, init = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [255:0] key = '0;
    logic [3:0]   round, rd_mon = 4'd0, rd_stim = 4'd0;
    logic         mon_active = 1'b0;
    logic [127:0] round_key;
    logic         ready, busy, mode_err;
    logic [31:0]  sub_in, sub_out;
`ifdef AES_KEY_ZEROIZE_EN
    logic         zeroize = 1'b0;
`endif

    logic [0:255][7:0] sbox_tab = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;
    assign round   = mon_active ? rd_mon : rd_stim;
    assign sub_out = {sbox_tab[sub_in[31:24]], sbox_tab[sub_in[23:16]],
                      sbox_tab[sub_in[15:8]], sbox_tab[sub_in[7:0]]};

    aes_key_expand dut (
        .clk(clk), .reset(reset),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .init(init), .mode(mode), .key(key), .round(round), .round_key(round_key),
        .ready(ready), .busy(busy), .mode_err(mode_err), .sub_in(sub_in), .sub_out(sub_out));

    int chk_cnt = 0, err_cnt = 0, done_cnt = 0, cyc = 0, init_edge = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [3:0] rnd; logic [127:0] val; } rk_t;
    int  lat_q[$];
    int  nrk_q[$];
    rk_t rk_q[$];
    int  err_exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_rk(input logic [3:0] r, input logic [127:0] v);
        rk_t e;
        e.rnd = r;
        e.val = v;
        rk_q.push_back(e);
    endtask

    task automatic start(input logic [1:0] m, input logic [255:0] k);
        @(negedge clk);
        mode = m;
        key  = k;
        init = 1'b1;
        @(posedge clk);
        #1;
        init_edge = cyc;
        init = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt < target) begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL timeout: completions %0d expected %0d", done_cnt, target);
            lat_q.delete(); nrk_q.delete(); rk_q.delete(); err_exp_q.delete();
            done_cnt = target;
        end
    endtask

    // Monitor: pops expectations whenever ready or mode_err rises.
    initial begin
        logic rdy_p, err_p;
        rdy_p = 1'b0;
        err_p = 1'b0;
        forever begin
            @(negedge clk);
            if (ready && !rdy_p) begin
                if (lat_q.size() == 0) begin
                    chk_cnt++; err_cnt++;
                    $display("FAIL unexpected_ready: got 1 expected 0");
                end else begin
                    int lat, n;
                    lat = lat_q.pop_front();
                    n   = nrk_q.pop_front();
                    check("latency", 128'(cyc - init_edge), 128'(lat));
                    mon_active = 1'b1;
                    for (int k = 0; k < n; k++) begin
                        rk_t e;
                        e = rk_q.pop_front();
                        rd_mon = e.rnd;
                        #1;
                        check($sformatf("round_key[%0d]", e.rnd), round_key, e.val);
                    end
                    mon_active = 1'b0;
                    done_cnt++;
                end
            end
            if (mode_err && !err_p) begin
                if (err_exp_q.size() == 0) begin
                    chk_cnt++; err_cnt++;
                    $display("FAIL unexpected_mode_err: got 1 expected 0");
                end else begin
                    void'(err_exp_q.pop_front());
                    check("mode_err_ready", 128'(ready), 128'(0));
                    check("mode_err_busy", 128'(busy), 128'(0));
                    done_cnt++;
                end
            end
            rdy_p = ready;
            err_p = mode_err;
        end
    end

    initial begin
        logic saw_busy;
        #2;
        check("rst_ready", 128'(ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_mode_err", 128'(mode_err), 128'(0));
        check("rst_round_key", round_key, 128'h0);
        check("rst_sub_in", 128'(sub_in), 128'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // AES-128
        lat_q.push_back(46); nrk_q.push_back(3);
        push_rk(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        push_rk(4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        push_rk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        start(2'd0, K128);
        check("busy_after_init", 128'(busy), 128'(1));
        wait_done(1);

        // AES-256
        lat_q.push_back(62); nrk_q.push_back(3);
        push_rk(4'd0, 128'h603deb1015ca71be2b73aef0857d7781);
        push_rk(4'd1, 128'h1f352c073b6108d72d9810a30914dff4);
        push_rk(4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        start(2'd2, K256);
        wait_done(2);

        // Reserved mode
        err_exp_q.push_back(1);
        start(2'd3, K128);
        saw_busy = busy;
        repeat (5) begin
            @(negedge clk);
            saw_busy = saw_busy | busy;
        end
        check("mode3_no_busy", 128'(saw_busy), 128'(0));
        wait_done(3);

        // AES-192 with key/mode changed after init and a stray init mid-GEN
        lat_q.push_back(54); nrk_q.push_back(3);
        push_rk(4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5);
        push_rk(4'd1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        push_rk(4'd12, 128'he98ba06f448c773c8ecc720401002202);
        start(2'd1, K192);
        check("mode_err_cleared", 128'(mode_err), 128'(0));
        @(negedge clk);
        key  = '1;
        mode = 2'd2;
        repeat (10) @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        wait_done(4);

        // Reset around i = 20, then rerun AES-128
        start(2'd0, K128);
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_ready", 128'(ready), 128'(0));
        foreach (rk_q[i]) ; // queue is empty here; no expectations outstanding
        rd_stim = 4'd0; #1; check("abort_round0", round_key, 128'h0);
        rd_stim = 4'd1; #1; check("abort_round1", round_key, 128'h0);
        rd_stim = 4'd4; #1; check("abort_round4", round_key, 128'h0);
        @(negedge clk);
        reset = 1'b1;

        lat_q.push_back(46); nrk_q.push_back(4);
        push_rk(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        push_rk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        push_rk(4'd11, 128'h0);
        push_rk(4'd15, 128'h0);
        start(2'd0, K128);
        wait_done(5);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule
